gcd_rr_scheduler: RTL
=====================

Name: gcd_rr_scheduler

Overview:
Round-robin scheduler that shares one GCD engine (controller plus datapath, go/done handshake) among N_REQ requesters. It arbitrates requests, launches the engine with the winning operands, waits for done under a watchdog, and returns the result tagged with the requester ID. Zero operands are answered locally because the engine never terminates on them. The block sits between the requester fabric and the GCD engine top.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 8, operand/result width; matches engine data width
TIMEOUT, 1023, max cycles in WAIT before abort (>=2)
ID_W, clog2(N_REQ), requester ID width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester request
req_a  in  N_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
req_b  in  N_REQ*WIDTH  operand B, same packing
req_ready  out  N_REQ  one-hot accept pulse; handshake when valid&ready
rsp_valid  out  1  one-cycle response pulse
rsp_id  out  ID_W  requester being answered
rsp_data  out  WIDTH  GCD result
rsp_err  out  1  timeout flag, valid with rsp_valid
eng_go  out  1  one-cycle start pulse to engine
eng_a  out  WIDTH  operand to engine data_in1 (held stable from ISSUE to RESP)
eng_b  out  WIDTH  operand to engine data_in2
eng_clr  out  1  one-cycle engine clear on timeout (integration ORs into engine reset)
eng_done  in  1  engine done; held >=1 cycle
eng_out  in  WIDTH  engine result, valid while eng_done=1
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, rr_ptr=0, all outputs 0, latched operands/ID 0, timer 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: winner is the first requester with req_valid=1 searching ptr, ptr+1, ... mod N_REQ. req_ready[winner]=1 combinationally in the same cycle. Operands and ID are latched at the edge. Next state is RESP if either operand is 0, else ISSUE. No valid request: stay in IDLE, req_ready=0.
- Zero rule: a=0 gives result b; b=0 gives a; both 0 gives 0, err=0. The engine is not touched.
- ISSUE: eng_go=1 for exactly one cycle; timer cleared; go to WAIT.
- WAIT: timer increments each cycle.
  - eng_done=1: capture eng_out into result, err=0, go to RESP.
  - Otherwise, timer==TIMEOUT-1: result=0, err=1, eng_clr=1 this cycle, go to RESP.
  - eng_done and timeout in the same cycle: done wins, no error.
- RESP: rsp_valid=1 for one cycle with rsp_id, rsp_data, rsp_err. rr_ptr becomes (id+1) mod N_REQ. Go to IDLE.
- rsp_id/rsp_data/rsp_err hold their values until the next RESP. They are only meaningful while rsp_valid=1.
- req_ready is 0 outside IDLE. At most one request is in flight; no queuing.
- Latency (handshake cycle = 0):
  - Engine path: eng_go at cycle 1, rsp_valid at (cycle of first eng_done)+1.
  - Zero path: rsp_valid at cycle 1.
- eng_done while not in WAIT (stale or level-held): ignored.
- eng_a/eng_b are driven from the latch registers, so they are stable throughout each transaction.
- Reset asserted mid-transaction: immediate return to reset values, in-flight request dropped, no response. The requester must re-request.

Decomposition:
- Shared package gcd_pkg holds the state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3, 2-bit) and the default WIDTH constant, reused by the GCD engine controller.
- One sub-module, rr_arbiter_comb: combinational round-robin pick from req_valid and ptr, producing a one-hot grant, a binary ID, and an any flag.
- The FSM, timer, and operand latches stay in the top.

Test Plan:
- Single request: req 2 with a=48, b=18, engine model delays done 10 cycles → eng_go one cycle after handshake, eng_a=48, eng_b=18, then rsp_valid with id=2, data=6, err=0.
- Fairness: all 4 valid continuously, ptr=0 → grant order 0,1,2,3,0. No requester served twice before the others.
- Zero operand: req 1 with a=0, b=35 → rsp at cycle 1 with data=35, eng_go never asserted. Same for a=0, b=0 → data=0.
- Timeout: TIMEOUT=16, engine never asserts done → eng_clr pulse and rsp_err=1, data=0, on the 16th WAIT cycle. Next request is served normally.
- Done on the final timeout cycle → data=eng_out, err=0, eng_clr=0. Stale eng_done held high into IDLE → no spurious response.
- Reset asserted during WAIT → all outputs 0 next sample, ptr=0, no rsp_valid after release until a new request.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD engine and its front-end scheduler.
// The state encoding is reused by the engine controller, so keep it stable.
package gcd_pkg;

    // Default operand/result width of the GCD engine datapath.
    localparam int GCD_WIDTH = 8;

    // 2-bit state encoding shared by the scheduler and the engine controller.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

endpackage

// File: rtl/gcd_rr_scheduler_arb.sv
// Combinational round-robin pick: the first asserted request found when
// searching ptr, ptr+1, ... wrapping modulo N_REQ.
module rr_arbiter_comb #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  id,
    output logic             any_req
);

    // One extra bit so ptr + offset never overflows before the wrap.
    logic [ID_W:0]   idx_sum;
    logic [ID_W-1:0] idx;

    // Walk the rotated search order and keep only the first hit.
    always_comb begin
        grant   = '0;
        id      = '0;
        any_req = 1'b0;
        idx_sum = '0;
        idx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (idx_sum >= (ID_W+1)'(N_REQ)) begin
                idx_sum = idx_sum - (ID_W+1)'(N_REQ);
            end
            idx = idx_sum[ID_W-1:0];
            if (!any_req && req[idx]) begin
                any_req    = 1'b1;
                id         = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gcd_rr_scheduler.sv
// Round-robin front end sharing one GCD engine among N_REQ requesters.
// Zero operands are answered locally; the engine would never finish on them.
//
// state | meaning
// IDLE  | arbitrate, accept winner, latch operands/ID
// ISSUE | one-cycle eng_go, clear watchdog timer
// WAIT  | wait for eng_done; abort with eng_clr on watchdog expiry
// RESP  | one-cycle rsp_valid, advance round-robin pointer past winner
module gcd_rr_scheduler
    import gcd_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int WIDTH   = GCD_WIDTH,
    parameter  int TIMEOUT = 1023,
    localparam int ID_W    = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   rsp_err,
    output logic                   eng_go,
    output logic [WIDTH-1:0]       eng_a,
    output logic [WIDTH-1:0]       eng_b,
    output logic                   eng_clr,
    input  logic                   eng_done,
    input  logic [WIDTH-1:0]       eng_out,
    output logic                   busy
);

    // Timer only has to reach TIMEOUT-1 before the FSM leaves WAIT.
    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [1:0]       state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  lat_id;
    logic [WIDTH-1:0] lat_a;
    logic [WIDTH-1:0] lat_b;
    logic [TMR_W-1:0] timer;

    logic [N_REQ-1:0] win_grant;
    logic [ID_W-1:0]  win_id;
    logic             win_any;
    logic [WIDTH-1:0] win_a;
    logic [WIDTH-1:0] win_b;
    logic             win_zero;
    logic             timed_out;

    rr_arbiter_comb #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .grant   (win_grant),
        .id      (win_id),
        .any_req (win_any)
    );

    // Winner operands, zero detection and Moore/Mealy output decode.
    always_comb begin
        win_a     = req_a[int'(win_id)*WIDTH +: WIDTH];
        win_b     = req_b[int'(win_id)*WIDTH +: WIDTH];
        win_zero  = (win_a == '0) || (win_b == '0);
        timed_out = (timer == TMR_W'(TIMEOUT - 1));
        req_ready = (state == IDLE) ? win_grant : '0;
        eng_go    = (state == ISSUE);
        eng_clr   = (state == WAIT) && !eng_done && timed_out;
        rsp_valid = (state == RESP);
        busy      = (state != IDLE);
        eng_a     = lat_a;
        eng_b     = lat_b;
    end

    // FSM, watchdog timer, operand latches and held response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            lat_id   <= '0;
            lat_a    <= '0;
            lat_b    <= '0;
            timer    <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_any) begin
                        lat_id <= win_id;
                        lat_a  <= win_a;
                        lat_b  <= win_b;
                        if (win_zero) begin
                            // gcd(0,x)=x; both zero falls out as 0.
                            rsp_id   <= win_id;
                            rsp_data <= (win_a == '0) ? win_b : win_a;
                            rsp_err  <= 1'b0;
                            state    <= RESP;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    timer <= timer + TMR_W'(1);
                    // A done on the final watchdog cycle still counts as success.
                    if (eng_done) begin
                        rsp_id   <= lat_id;
                        rsp_data <= eng_out;
                        rsp_err  <= 1'b0;
                        state    <= RESP;
                    end else if (timed_out) begin
                        rsp_id   <= lat_id;
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    rr_ptr <= (lat_id == ID_W'(N_REQ - 1)) ? '0 : lat_id + ID_W'(1);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
